muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit for the multicycle processor datapath; next generation of the existing mult block.
- Adds parametrised width, signed/unsigned multiply and divide modes, a start/busy/done handshake and a divide-by-zero flag.
- Results land in HI/LO per MIPS convention: product in HI:LO; quotient in LO, remainder in HI.
- Driven by the control unit FSM, which stalls on busy and samples hi/lo after done.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 130 +++++++++++++
 tb/tb_muldiv_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Start/busy/done handshake and operand/result bus for the iterative
// multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output x, y, start, op,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  x, y, start, op,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO results.
// One WIDTH+1 bit adder is shared by both modes; signs are fixed up at the end.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] acc, q, m;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic [CNT_W-1:0] cnt;
    logic             is_div, neg_q, neg_r;
    logic             done_r, dz_r;

    logic             accept, zero_div, sgn, x_neg, y_neg;
    logic [WIDTH-1:0] xa, ya;
    logic [WIDTH:0]   add_a, add_b;
    logic [WIDTH+1:0] sum;
    logic             ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    always_comb begin
        sgn      = ~bus.op[0];
        x_neg    = sgn & bus.x[WIDTH-1];
        y_neg    = sgn & bus.y[WIDTH-1];
        xa       = x_neg ? -bus.x : bus.x;
        ya       = y_neg ? -bus.y : bus.y;
        accept   = bus.start && (state != RUN);
        zero_div = bus.op[1] && (bus.y == '0);
    end

    // Divide: trial subtract of {rem,next bit} - divisor; multiply: acc + m.
    always_comb begin
        add_a = is_div ? {acc, q[WIDTH-1]} : {1'b0, acc};
        add_b = is_div ? ~{1'b0, m} : (q[0] ? {1'b0, m} : '0);
        sum   = {1'b0, add_a} + {1'b0, add_b}
              + {{(WIDTH+1){1'b0}}, is_div};
        ge    = sum[WIDTH+1];
    end

    always_comb begin
        prod_fix = neg_q ? -{acc, q} : {acc, q};
        if (is_div) begin
            fix_lo = neg_q ? -q : q;
            fix_hi = neg_r ? -acc : acc;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && !zero_div) state_nx = RUN;
            end
            RUN: begin
                if (cnt == CNT_W'(1)) state_nx = FINISH;
            end
            FINISH: begin
                state_nx = (accept && !zero_div) ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            state  <= state_nx;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
                if (is_div) begin
                    acc <= ge ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], ge};
                end else begin
                    acc <= sum[WIDTH:1];
                    q   <= {sum[0], q[WIDTH-1:1]};
                end
            end
            if (state == FINISH) begin
                hi_r   <= fix_hi;
                lo_r   <= fix_lo;
                done_r <= 1'b1;
            end
            if (accept) begin
                if (zero_div) begin
                    done_r <= 1'b1;
                    dz_r   <= 1'b1;
                end else begin
                    acc    <= '0;
                    q      <= xa;
                    m      <= ya;
                    cnt    <= CNT_W'(WIDTH);
                    is_div <= bus.op[1];
                    neg_q  <= x_neg ^ y_neg;
                    neg_r  <= bus.op[1] & x_neg;
                end
            end
        end
    end

    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.busy     = (state == RUN);
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mhi, mlo;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [1:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint sa, sb;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'd0: begin p = sa * sb; {h, l} = p; end
            2'd1: begin p = ua * ub; {h, l} = p; end
            2'd2: if (b != 0) begin l = 32'(sa / sb); h = 32'(sa % sb); end
            default: if (b != 0) begin l = a / b; h = a % b; end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        mhi = '0;
        mlo = '0;
    endtask

    // Drives one start and waits (bounded) for done; lat counts edges after the start edge.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output int lat, output int bcnt, output logic dz);
        bus.start = 1'b1;
        bus.op = op;
        bus.x = a;
        bus.y = b;
        tick();
        bus.start = 1'b0;
        bus.x = $urandom;
        bus.y = $urandom;
        bus.op = 2'($urandom);
        lat = -1;
        bcnt = 0;
        dz = 1'b0;
        rh = 'x;
        rl = 'x;
        for (int k = 0; k <= 40; k++) begin
            if (bus.done) begin
                lat = k;
                rh = bus.hi;
                rl = bus.lo;
                dz = bus.div_zero;
                break;
            end
            bcnt += int'(bus.busy);
            tick();
        end
        vectors++;
        if (lat < 0) begin
            miscompares++;
            $display("FAIL timeout op=%0d: done not seen within 40 cycles", op);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.x = '0;
        bus.y = '0;
        tick();
        tick();
        vectors++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset hi/lo: got %h_%h required 0", bus.hi, bus.lo);
        end
        vectors++;
        if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset flags busy/done/dz: got %b required 000",
                     {bus.busy, bus.done, bus.div_zero});
        end
        reset = 1'b0;
        tick();
        vectors++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            miscompares++;
            $display("FAIL post-reset idle: got %b required 00", {bus.busy, bus.done});
        end
        mhi = '0;
        mlo = '0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, eh, el;
    } vec_t;

    task automatic test_directed();
        vec_t t[8];
        logic [31:0] rh, rl;
        int lat, bcnt, elat, ebusy;
        logic dz, edz;
        t[0] = '{2'd0, 32'd1000000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFD2_3940};
        t[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        t[2] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1};
        t[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        t[4] = '{2'd3, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC};
        t[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
        t[6] = '{2'd3, 32'd5, 32'd2, 32'h1, 32'h2};
        t[7] = '{2'd2, 32'd5, 32'd0, 32'h1, 32'h2};
        for (int i = 0; i < 8; i++) begin
            edz = (t[i].op[1] && t[i].b == 0);
            elat = edz ? 0 : 33;
            ebusy = edz ? 0 : 32;
            do_op(t[i].op, t[i].a, t[i].b, rh, rl, lat, bcnt, dz);
            vectors++;
            if ({rh, rl} !== {t[i].eh, t[i].el}) begin
                miscompares++;
                $display("FAIL dir%0d hi/lo: got %h_%h required %h_%h",
                         i, rh, rl, t[i].eh, t[i].el);
            end
            vectors++;
            if (lat != elat || bcnt != ebusy) begin
                miscompares++;
                $display("FAIL dir%0d timing: latency %0d busy %0d required %0d/%0d",
                         i, lat, bcnt, elat, ebusy);
            end
            vectors++;
            if (dz !== edz) begin
                miscompares++;
                $display("FAIL dir%0d div_zero: got %b required %b", i, dz, edz);
            end
            tick();
            vectors++;
            if ({bus.done, bus.div_zero, bus.busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL dir%0d pulse width: done/dz/busy %b required 000",
                         i, {bus.done, bus.div_zero, bus.busy});
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [1:0] op;
        logic [31:0] a, b, eh, el, rh, rl;
        int lat, bcnt;
        logic dz, edz;
        do_reset();
        tick();
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom);
            a = pick();
            b = pick();
            eh = mhi;
            el = mlo;
            model(op, a, b, eh, el);
            edz = (op[1] && b == 0);
            do_op(op, a, b, rh, rl, lat, bcnt, dz);
            vectors++;
            if ({rh, rl} !== {eh, el}) begin
                miscompares++;
                $display("FAIL rand%0d op=%0d x=%h y=%h: got %h_%h required %h_%h",
                         i, op, a, b, rh, rl, eh, el);
            end
            vectors++;
            if (dz !== edz || lat != (edz ? 0 : 33) || bcnt != (edz ? 0 : 32)) begin
                miscompares++;
                $display("FAIL rand%0d handshake: dz %b lat %0d busy %0d required %b/%0d/%0d",
                         i, dz, lat, bcnt, edz, edz ? 0 : 33, edz ? 0 : 32);
            end
            mhi = eh;
            mlo = el;
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int lat;
        lat = -1;
        bus.start = 1'b1;
        bus.op = 2'd0;
        bus.x = 32'd100;
        bus.y = 32'd100;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k == 4) begin
                bus.start = 1'b1;
                bus.op = 2'd3;
                bus.x = 32'd77;
                bus.y = 32'd5;
            end
            if (k == 5) bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            tick();
        end
        vectors++;
        if (lat != 33) begin
            miscompares++;
            $display("FAIL ignored_start latency: got %0d required 33", lat);
        end
        vectors++;
        if ({bus.hi, bus.lo} !== {32'd0, 32'd10000}) begin
            miscompares++;
            $display("FAIL ignored_start result: got %h_%h required 0_%h",
                     bus.hi, bus.lo, 32'd10000);
        end
        tick();
        vectors++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            miscompares++;
            $display("FAIL ignored_start extra op: busy/done %b required 00",
                     {bus.busy, bus.done});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rh, rl;
        int lat, bcnt;
        logic dz;
        do_op(2'd1, 32'd123456, 32'd789, rh, rl, lat, bcnt, dz);
        vectors++;
        if ({rh, rl} !== {32'd0, 32'd97406784}) begin
            miscompares++;
            $display("FAIL b2b first: got %h_%h required 0_%h", rh, rl, 32'd97406784);
        end
        do_op(2'd3, 32'd1000, 32'd7, rh, rl, lat, bcnt, dz);
        vectors++;
        if ({rh, rl} !== {32'd6, 32'd142} || lat != 33) begin
            miscompares++;
            $display("FAIL b2b second: got %h_%h lat %0d required %h_%h lat 33",
                     rh, rl, lat, 32'd6, 32'd142);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        bus.start = 1'b1;
        bus.op = 2'd0;
        bus.x = 32'h1234_5678;
        bus.y = 32'h9ABC_DEF0;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({bus.busy, bus.done} !== 2'b00 || {bus.hi, bus.lo} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_mid state: busy/done %b hi/lo %h_%h required 00 0_0",
                     {bus.busy, bus.done}, bus.hi, bus.lo);
        end
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) seen++;
            tick();
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_mid aborted op: %0d busy/done cycles required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random(200);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
